game_flow_ctrl: RTL and testbench
=================================

// Module: game_flow_ctrl
// PURPOSE
//  Top-level game-flow state machine that produces the gameEnded level consumed by the end-screen
//  renderer and the freeze/playing qualifiers consumed by the movers and score logic.
//  Tracks lives and level number and times death/level-transition pauses in whole frames using
//  startOfFrame. One instance per design, clocked with the VGA pixel clock.
// PARAMETERS
//  START_LIVES      3    lives loaded on game start (1..7)
//  MAX_LEVEL        8    highest level number; next level after MAX_LEVEL wraps to 1 (1..15)
//  DEATH_FRAMES     60   frames frozen after a hit before respawn/game over (1..255)
//  LEVEL_FRAMES     90   frames frozen after level cleared before next level (1..255)
//  GAMEOVER_FRAMES  120  minimum frames in GAME_OVER before startKey is honoured (1..255)
// PORTS
//  clk           in   1  system/pixel clock
//  resetN        in   1  asynchronous active-low reset
//  startOfFrame  in   1  one-cycle pulse per video frame
//  startKey      in   1  start/restart key level (already synchronised to clk)
//  playerHit     in   1  one-cycle pulse: player killed
//  levelCleared  in   1  one-cycle pulse: all emeralds collected
//  extraLife     in   1  one-cycle pulse: bonus life awarded
//  gameEnded     out  1  high while in GAME_OVER (drives end-screen display)
//  gamePlaying   out  1  high while in PLAYING
//  freeze        out  1  high in DYING and LEVEL_DONE (movers hold position)
//  showTitle     out  1  high while in IDLE (title screen)
//  newLevel      out  1  one-cycle pulse: reload level map/objects
//  respawn       out  1  one-cycle pulse: return player/enemies to start positions
//  lives         out  3  remaining lives
//  level         out  4  current level number, 1..MAX_LEVEL
// BEHAVIOUR
//  Reset (async, resetN=0): state=IDLE, showTitle=1, all other 1-bit outputs 0, lives=0, level=1,
//   frame counter=0, startKey edge register=0. Deasserting reset mid-game always returns to IDLE.
//  startKey is edge-detected: a press is startKey=1 while the previous-cycle sample=0.
//   A key held through a transition never re-triggers.
//  Frame counter (8 bit) clears on every state entry and increments only on startOfFrame cycles.
//  All outputs are registered; they reflect the new state one clk after the transition cycle.
//  States / transitions (evaluated each clk):
//   IDLE      : press -> PLAYING; lives<=START_LIVES, level<=1, newLevel pulse.
//   PLAYING   : playerHit -> DYING, lives<=lives-1 (same edge).
//               else levelCleared -> LEVEL_DONE.
//               playerHit wins if both arrive in the same cycle; levelCleared is dropped.
//   DYING     : on the startOfFrame cycle on which the count reaches DEATH_FRAMES:
//               lives==0 -> GAME_OVER; else -> PLAYING with respawn pulse.
//   LEVEL_DONE: on the startOfFrame cycle on which the count reaches LEVEL_FRAMES -> PLAYING;
//               level<=level+1 (MAX_LEVEL wraps to 1); newLevel pulse and respawn pulse.
//   GAME_OVER : count < GAMEOVER_FRAMES -> presses ignored.
//               After that, a press -> IDLE. The count saturates at 255.
//  extraLife: lives<=lives+1, saturating at 7; honoured in PLAYING, DYING and LEVEL_DONE.
//   Ignored in IDLE and GAME_OVER.
//  extraLife coinciding with playerHit: net lives change is 0; state still goes to DYING.
//  playerHit/levelCleared are ignored outside PLAYING.
//  newLevel/respawn are exactly one clk wide, asserted on the first cycle of the new state.
//  lives never underflows: entering DYING with lives==0 is impossible by construction.
// TESTING
//  1 Reset, press startKey -> next clk gamePlaying=1, lives=3, level=1, newLevel high one cycle.
//  2 PLAYING, pulse playerHit -> freeze=1, lives=2. After 60 startOfFrame pulses:
//    gamePlaying=1, respawn one-cycle pulse.
//  3 Three hits (lives 3->0) -> after 60 frames in the third DYING, gameEnded=1.
//    Key press at frame 50 is ignored; press after frame 120 -> showTitle=1, gameEnded=0.
//  4 playerHit and levelCleared in the same cycle -> DYING, level unchanged.
//    Level-clear at level 8 -> after 90 frames level=1, newLevel pulse.
//  5 extraLife x6 from lives=3 -> lives=7 (saturates). extraLife with playerHit -> lives unchanged.
//  6 Assert resetN=0 mid-DYING -> outputs reach reset values immediately.
//    Hold startKey through release of reset -> stays IDLE until the key is released and pressed again.

Source files
------------

// File: rtl/game_flow_ctrl_if.sv
// Game-flow event inputs and status outputs shared between the flow controller
// and the movers/score/renderer blocks around it.
interface game_flow_ctrl_if;
  logic       startOfFrame;
  logic       startKey;
  logic       playerHit;
  logic       levelCleared;
  logic       extraLife;
  logic       gameEnded;
  logic       gamePlaying;
  logic       freeze;
  logic       showTitle;
  logic       newLevel;
  logic       respawn;
  logic [2:0] lives;
  logic [3:0] level;

  modport master (
    output startOfFrame, startKey, playerHit, levelCleared, extraLife,
    input  gameEnded, gamePlaying, freeze, showTitle, newLevel, respawn, lives, level
  );

  modport slave (
    input  startOfFrame, startKey, playerHit, levelCleared, extraLife,
    output gameEnded, gamePlaying, freeze, showTitle, newLevel, respawn, lives, level
  );
endinterface

// File: rtl/game_flow_ctrl.sv
// Game-flow state machine: title, play, death/level pauses timed in frames, game over.
// All outputs are registered from the next-state values.
module game_flow_ctrl #(
  parameter int START_LIVES     = 3,
  parameter int MAX_LEVEL       = 8,
  parameter int DEATH_FRAMES    = 60,
  parameter int LEVEL_FRAMES    = 90,
  parameter int GAMEOVER_FRAMES = 120
) (
  input logic             clk,
  input logic             resetN,
  game_flow_ctrl_if.slave gf
);
  // state        | meaning
  // S_IDLE       | title screen, waiting for a start press
  // S_PLAYING    | normal play
  // S_DYING      | frozen after a hit, counting DEATH_FRAMES
  // S_LEVEL_DONE | frozen after level clear, counting LEVEL_FRAMES
  // S_GAME_OVER  | end screen, press honoured after GAMEOVER_FRAMES
  typedef enum logic [2:0] {
    S_IDLE, S_PLAYING, S_DYING, S_LEVEL_DONE, S_GAME_OVER
  } state_t;

  localparam logic [7:0] DEATH_LAST = 8'(DEATH_FRAMES - 1);
  localparam logic [7:0] LEVEL_LAST = 8'(LEVEL_FRAMES - 1);
  localparam logic [7:0] GO_MIN     = 8'(GAMEOVER_FRAMES);
  localparam logic [2:0] LIVES_INIT = 3'(START_LIVES);
  localparam logic [3:0] LEVEL_TOP  = 4'(MAX_LEVEL);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       key_prev_q, key_prev_d;
  logic       key_armed_q, key_armed_d;
  logic [2:0] lives_q, lives_d;
  logic [3:0] level_q, level_d;
  logic       game_ended_q, game_ended_d;
  logic       game_playing_q, game_playing_d;
  logic       freeze_q, freeze_d;
  logic       show_title_q, show_title_d;
  logic       new_level_q, new_level_d;
  logic       respawn_q, respawn_d;
  logic       press, hit_now, lives_live;

  // A key held across reset release must first be seen low before it can count as a press.
  assign press      = gf.startKey & ~key_prev_q & key_armed_q;
  assign hit_now    = (state_q == S_PLAYING) & gf.playerHit;
  assign lives_live = (state_q == S_PLAYING) | (state_q == S_DYING) | (state_q == S_LEVEL_DONE);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      key_prev_q     <= 1'b0;
      key_armed_q    <= 1'b0;
      lives_q        <= '0;
      level_q        <= 4'd1;
      game_ended_q   <= 1'b0;
      game_playing_q <= 1'b0;
      freeze_q       <= 1'b0;
      show_title_q   <= 1'b1;
      new_level_q    <= 1'b0;
      respawn_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      key_prev_q     <= key_prev_d;
      key_armed_q    <= key_armed_d;
      lives_q        <= lives_d;
      level_q        <= level_d;
      game_ended_q   <= game_ended_d;
      game_playing_q <= game_playing_d;
      freeze_q       <= freeze_d;
      show_title_q   <= show_title_d;
      new_level_q    <= new_level_d;
      respawn_q      <= respawn_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:       if (press) state_d = S_PLAYING;
      S_PLAYING: begin
        if (gf.playerHit)         state_d = S_DYING;
        else if (gf.levelCleared) state_d = S_LEVEL_DONE;
      end
      S_DYING:
        if (gf.startOfFrame && cnt_q == DEATH_LAST)
          state_d = (lives_q == 3'd0) ? S_GAME_OVER : S_PLAYING;
      S_LEVEL_DONE:
        if (gf.startOfFrame && cnt_q == LEVEL_LAST) state_d = S_PLAYING;
      S_GAME_OVER:  if (press && cnt_q >= GO_MIN) state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q)                        cnt_d = '0;
    else if (gf.startOfFrame && cnt_q != 8'hFF)    cnt_d = cnt_q + 8'd1;

    key_prev_d  = gf.startKey;
    key_armed_d = key_armed_q | ~gf.startKey;

    lives_d = lives_q;
    if (state_q == S_IDLE && state_d == S_PLAYING) begin
      lives_d = LIVES_INIT;
    end else if (lives_live) begin
      if (hit_now && !gf.extraLife)                        lives_d = lives_q - 3'd1;
      else if (!hit_now && gf.extraLife && lives_q != 3'd7) lives_d = lives_q + 3'd1;
    end

    level_d = level_q;
    if (state_q == S_IDLE && state_d == S_PLAYING)
      level_d = 4'd1;
    else if (state_q == S_LEVEL_DONE && state_d == S_PLAYING)
      level_d = (level_q >= LEVEL_TOP) ? 4'd1 : level_q + 4'd1;

    game_ended_d   = (state_d == S_GAME_OVER);
    game_playing_d = (state_d == S_PLAYING);
    freeze_d       = (state_d == S_DYING) || (state_d == S_LEVEL_DONE);
    show_title_d   = (state_d == S_IDLE);
    new_level_d    = (state_d == S_PLAYING) &&
                     (state_q == S_IDLE || state_q == S_LEVEL_DONE);
    respawn_d      = (state_d == S_PLAYING) &&
                     (state_q == S_DYING || state_q == S_LEVEL_DONE);
  end

  assign gf.gameEnded   = game_ended_q;
  assign gf.gamePlaying = game_playing_q;
  assign gf.freeze      = freeze_q;
  assign gf.showTitle   = show_title_q;
  assign gf.newLevel    = new_level_q;
  assign gf.respawn     = respawn_q;
  assign gf.lives       = lives_q;
  assign gf.level       = level_q;
endmodule

// File: tb/tb_game_flow_ctrl.sv
// Scoreboard bench for game_flow_ctrl: directed game scenarios plus random events,
// expected outputs come from a rule-level game model.
module tb_game_flow_ctrl;
  localparam int START_LIVES     = 3;
  localparam int MAX_LEVEL       = 8;
  localparam int DEATH_FRAMES    = 60;
  localparam int LEVEL_FRAMES    = 90;
  localparam int GAMEOVER_FRAMES = 120;

  localparam int M_TITLE = 0, M_PLAY = 1, M_DEAD = 2, M_CLEAR = 3, M_OVER = 4;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  game_flow_ctrl_if gf();

  game_flow_ctrl #(
    .START_LIVES(START_LIVES), .MAX_LEVEL(MAX_LEVEL), .DEATH_FRAMES(DEATH_FRAMES),
    .LEVEL_FRAMES(LEVEL_FRAMES), .GAMEOVER_FRAMES(GAMEOVER_FRAMES)
  ) dut (
    .clk(clk), .resetN(resetN), .gf(gf)
  );

  int checks = 0;
  int passed = 0;
  logic [12:0] exp_q[$];

  int m_mode, m_lives, m_level, m_frames;
  bit m_kprev, m_armed;

  function automatic logic [12:0] dut_out();
    return {gf.gameEnded, gf.gamePlaying, gf.freeze, gf.showTitle,
            gf.newLevel, gf.respawn, gf.lives, gf.level};
  endfunction

  function automatic int inc_sat7(input int v);
    return (v >= 7) ? 7 : v + 1;
  endfunction

  task automatic model_step(input bit rst, input bit sof, input bit key,
                            input bit hit, input bit clr, input bit ext);
    int  nmode;
    bit  nl, rs, pr;
    nl = 0; rs = 0;
    if (!rst) begin
      m_mode = M_TITLE; m_lives = 0; m_level = 1; m_frames = 0;
      m_kprev = 0; m_armed = 0;
    end else begin
      pr    = key && !m_kprev && m_armed;
      nmode = m_mode;
      case (m_mode)
        M_TITLE: if (pr) begin
          nmode = M_PLAY; m_lives = START_LIVES; m_level = 1; nl = 1;
        end
        M_PLAY: begin
          if (hit) begin
            nmode = M_DEAD;
            if (!ext) m_lives = m_lives - 1;
          end else begin
            if (ext) m_lives = inc_sat7(m_lives);
            if (clr) nmode = M_CLEAR;
          end
        end
        M_DEAD: begin
          if (sof && m_frames + 1 == DEATH_FRAMES) begin
            nmode = (m_lives == 0) ? M_OVER : M_PLAY;
            rs = (nmode == M_PLAY);
          end
          if (ext) m_lives = inc_sat7(m_lives);
        end
        M_CLEAR: begin
          if (ext) m_lives = inc_sat7(m_lives);
          if (sof && m_frames + 1 == LEVEL_FRAMES) begin
            nmode = M_PLAY; nl = 1; rs = 1;
            m_level = (m_level == MAX_LEVEL) ? 1 : m_level + 1;
          end
        end
        default: if (pr && m_frames >= GAMEOVER_FRAMES) nmode = M_TITLE;
      endcase
      if (nmode != m_mode) m_frames = 0;
      else if (sof && m_frames < 255) m_frames = m_frames + 1;
      m_mode  = nmode;
      m_kprev = key;
      if (!key) m_armed = 1;
    end
    exp_q.push_back({m_mode == M_OVER, m_mode == M_PLAY,
                     m_mode == M_DEAD || m_mode == M_CLEAR, m_mode == M_TITLE,
                     nl, rs, 3'(m_lives), 4'(m_level)});
  endtask

  task automatic drive(input bit rst, input bit sof, input bit key,
                       input bit hit, input bit clr, input bit ext);
    @(negedge clk);
    resetN          = rst;
    gf.startOfFrame = sof;
    gf.startKey     = key;
    gf.playerHit    = hit;
    gf.levelCleared = clr;
    gf.extraLife    = ext;
    model_step(rst, sof, key, hit, clr, ext);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) drive(1, 1, 0, 0, 0, 0);
  endtask

  task automatic press_key();
    drive(1, 0, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    logic [12:0] e, a;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = dut_out();
        checks++;
        if (a === e) passed++;
        else $display("FAIL outputs t=%0t act={end,play,frz,title,nl,rs,lives,lvl}=%b_%b_%b_%b_%b_%b_%0d_%0d exp=%b_%b_%b_%b_%b_%b_%0d_%0d",
                      $time, a[12], a[11], a[10], a[9], a[8], a[7], a[6:4], a[3:0],
                      e[12], e[11], e[10], e[9], e[8], e[7], e[6:4], e[3:0]);
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog time limit expired act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [12:0] a;
    bit key, sof, hit, clr, ext;
    int r;
    gf.startOfFrame = 0; gf.startKey = 0; gf.playerHit = 0;
    gf.levelCleared = 0; gf.extraLife = 0;
    repeat (3) drive(0, 0, 0, 0, 0, 0);
    repeat (2) drive(1, 0, 0, 0, 0, 0);

    // start, then clear all levels so the level number wraps
    press_key();
    for (int lv = 0; lv < MAX_LEVEL; lv++) begin
      drive(1, 0, 0, 0, 1, 0);
      frames(LEVEL_FRAMES);
      drive(1, 0, 0, 0, 0, 0);
    end
    // hit and clear together, then lose every life
    drive(1, 0, 0, 1, 1, 0);
    frames(DEATH_FRAMES);
    for (int k = 0; k < 2; k++) begin
      drive(1, 0, 0, 1, 0, 0);
      frames(DEATH_FRAMES);
    end
    frames(50);
    press_key();
    frames(GAMEOVER_FRAMES - 50 + 2);
    press_key();
    // extra lives saturate, extra life with a hit cancels out
    press_key();
    repeat (6) drive(1, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 1, 0, 1);
    frames(10);

    // async reset in the middle of DYING with the key held
    @(negedge clk);
    #2;
    resetN = 0;
    gf.startKey = 1;
    #1;
    a = dut_out();
    checks++;
    if (a === 13'b0_0_0_1_0_0_000_0001) passed++;
    else $display("FAIL async_reset act=%b exp=%b", a, 13'b0_0_0_1_0_0_000_0001);
    repeat (3) drive(0, 0, 1, 0, 0, 0);
    repeat (5) drive(1, 1, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    press_key();
    frames(5);

    key = 0;
    for (int i = 0; i < 30000; i++) begin
      if ($urandom_range(0, 19) == 0) key = ~key;
      sof = ($urandom_range(0, 3) != 0);
      r   = $urandom_range(0, 299);
      hit = (r < 5);
      clr = (r >= 3 && r < 10);
      ext = (r >= 8 && r < 14) || (r == 3);
      drive(1, sof, key, hit, clr, ext);
    end

    repeat (3) @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain act=%0d pending exp=0 pending", exp_q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
